// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, condition-flag bit positions and the
// buffered result entry layout.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 5;
  localparam int unsigned FLAG_W    = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [FLAG_W-1:0]    flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_stage_if.sv
// Upstream (subtractor result) and downstream (writeback) handshake bundle of
// the ALU flag stage.
interface alu_flag_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic              in_borrow;
  logic              in_a_msb;
  logic              in_b_msb;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [FLAG_W-1:0] out_flags;

  // Producer/consumer side (drives results in, accepts the head entry)
  modport master (
    output in_valid, in_result, in_borrow, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // Stage side
  modport slave (
    input  in_valid, in_result, in_borrow, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V flag generation for a subtract result; shared with
// future arithmetic stages.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  result,
  input  logic              borrow,
  input  logic              a_msb,
  input  logic              b_msb,
  output logic [FLAG_W-1:0] flags_c
);

  // Overflow: operands of opposite sign and result sign differs from a
  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_N] = result[WIDTH-1];
    flags_c[FLAG_Z] = (result == '0);
    flags_c[FLAG_C] = borrow;
    flags_c[FLAG_V] = (a_msb ^ b_msb) & (a_msb ^ result[WIDTH-1]);
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage after the subtractor: computes flags at push
// time and buffers {result, flags} entries in a small FIFO.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_flag_stage_if.slave  bus,
  input  logic             clr_sticky,
  output logic             sticky_v
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  alu_entry_t        mem_q [DEPTH];
  alu_entry_t        head_q, head_d;
  alu_entry_t        new_entry;
  logic [FLAG_W-1:0] new_flags_c;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, out_valid_q, sticky_q, sticky_d;
  logic              push, pop;

  alu_flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .result  (bus.in_result),
    .borrow  (bus.in_borrow),
    .a_msb   (bus.in_a_msb),
    .b_msb   (bus.in_b_msb),
    .flags_c (new_flags_c)
  );

  assign new_entry = '{result: ALU_WIDTH'(bus.in_result), flags: new_flags_c};

  // Next-state: pointers, occupancy, registered head entry and sticky overflow
  always_comb begin
    push     = bus.in_valid & in_ready_q;
    pop      = out_valid_q & bus.out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = '0;
    sticky_d = sticky_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // New head is the incoming entry when it lands in the slot being exposed
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = new_entry;
      else                                head_d = mem_q[rd_ptr_d];
    end

    if (pop && head_q.flags[FLAG_V]) sticky_d = 1'b1;
    else if (clr_sticky)             sticky_d = 1'b0;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      sticky_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d < CNT_W'(DEPTH));
      out_valid_q <= (count_d != '0);
      head_q      <= head_d;
      sticky_q    <= sticky_d;
    end
  end

  // Entry storage; contents are don't-care while not counted as occupied
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = WIDTH'(head_q.result);
  assign bus.out_flags  = head_q.flags;
  assign sticky_v       = sticky_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: flag encoding, sticky overflow, FIFO
// backpressure/ordering, streaming throughput and asynchronous reset.
module tb_alu_flag_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_sticky;
  logic sticky_v;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  alu_flag_stage_if #(.WIDTH(ALU_WIDTH)) bus ();

  alu_flag_stage #(
    .WIDTH (ALU_WIDTH),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [4:0] r,
                          input logic [3:0] f);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_result"}, 32'(bus.out_result), 32'(r));
    chk({tag, "_flags"}, 32'(bus.out_flags), 32'(f));
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic b,
                       input logic am, input logic bm);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_borrow = b;
    bus.in_a_msb  = am;
    bus.in_b_msb  = bm;
  endtask

  // Upstream must hold a stalled request unchanged until it is accepted
  always @(posedge clk) begin
    if (prev_stall) begin
      n_cmp++;
      assert (bus.in_valid && ({bus.in_result, bus.in_borrow, bus.in_a_msb, bus.in_b_msb} == prev_data))
      else begin
        n_fail++;
        $error("FAIL upstream_hold observed=%0h expected=%0h",
               {bus.in_result, bus.in_borrow, bus.in_a_msb, bus.in_b_msb}, prev_data);
      end
    end
    prev_stall <= rst_n && bus.in_valid && !bus.in_ready;
    prev_data  <= {bus.in_result, bus.in_borrow, bus.in_a_msb, bus.in_b_msb};
  end

  initial begin
    rst_n         = 1'b0;
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #1;
    chk_head("rst", 1'b0, 5'd0, 4'b0000);
    chk("rst_sticky", 32'(sticky_v), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", 32'(bus.in_ready), 32'd0);
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: 3-5 -> 11110, borrow, N and C
    drive(1'b1, 5'b11110, 1'b1, 1'b0, 1'b0);
    tick();
    chk_head("t1", 1'b1, 5'b11110, 4'b1010);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk_head("t1_pop", 1'b0, 5'd0, 4'b0000);

    // 2: 7-7 -> zero only
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_head("t2", 1'b1, 5'b00000, 4'b0100);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_pop_valid", 32'(bus.out_valid), 32'd0);

    // 3: overflow and sticky_v behaviour
    bus.out_ready = 1'b0;
    drive(1'b1, 5'b01111, 1'b0, 1'b1, 1'b0);
    tick();
    chk_head("t3", 1'b1, 5'b01111, 4'b0001);
    chk("t3_sticky_pre", 32'(sticky_v), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_sticky_set", 32'(sticky_v), 32'd1);
    chk("t3_empty", 32'(bus.out_valid), 32'd0);
    clr_sticky    = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    chk("t3_sticky_clr", 32'(sticky_v), 32'd0);
    clr_sticky = 1'b0;
    drive(1'b1, 5'b01111, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    clr_sticky    = 1'b1;
    tick();
    chk("t3_set_wins", 32'(sticky_v), 32'd1);
    bus.out_ready = 1'b0;
    tick();
    chk("t3_sticky_clr2", 32'(sticky_v), 32'd0);
    clr_sticky = 1'b0;

    // 4: backpressure, A/B accepted, C stalls, then ordered drain
    drive(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
    tick();
    chk_head("t4_a", 1'b1, 5'b00101, 4'b0000);
    chk("t4_ready_a", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 5'b10011, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t4_full_ready", 32'(bus.in_ready), 32'd0);
    chk_head("t4_full_head", 1'b1, 5'b00101, 4'b0000);
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_c_wait_ready", 32'(bus.in_ready), 32'd0);
    chk_head("t4_c_wait_head", 1'b1, 5'b00101, 4'b0000);
    bus.out_ready = 1'b1;
    tick();
    chk_head("t4_b", 1'b1, 5'b10011, 4'b1011);
    chk("t4_ready_after_pop", 32'(bus.in_ready), 32'd1);
    tick();
    chk_head("t4_c", 1'b1, 5'b00000, 4'b0100);
    chk("t4_sticky_b", 32'(sticky_v), 32'd1);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_drained", 32'(bus.out_valid), 32'd0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t4_sticky_clr", 32'(sticky_v), 32'd0);

    // 5: streaming, one result per cycle, occupancy stays at one
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0);
      tick();
      chk_head($sformatf("t5_%0d", i), 1'b1, 5'(i + 1), 4'b0000);
      chk($sformatf("t5_ready_%0d", i), 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t5_drained", 32'(bus.out_valid), 32'd0);

    // 6: async reset with two entries buffered and sticky_v set
    drive(1'b1, 5'b01111, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_sticky_set", 32'(sticky_v), 32'd1);
    bus.out_ready = 1'b0;
    drive(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_head("t6_buffered", 1'b1, 5'b00001, 4'b0000);
    chk("t6_full_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_head("t6_async", 1'b0, 5'd0, 4'b0000);
    chk("t6_async_sticky", 32'(sticky_v), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk_head("t6_after", 1'b0, 5'd0, 4'b0000);
    chk("t6_after_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_after_sticky", 32'(sticky_v), 32'd0);
    tick();
    chk("t6_stays_empty", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
